// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 execute stage.
//   alu_op_t   : ALU operation select (alu_ctrlE_i)
//   md_op_t    : M-extension operation select, encoded like funct3
//   fwd_sel_t  : operand forwarding select
//   md_state_t : iterative multiply/divide FSM states
//   F3_*       : branch funct3 encodings
// Helper functions give the operand signedness of each M-extension op.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Operand A is treated as two's complement for these ops.
    function automatic logic md_a_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Operand B is treated as two's complement for these ops.
    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32 M-extension unit: 32-step shift-add multiplier and
// restoring divider working on operand magnitudes, sign fixed up at the end.
// Build option: MULDIV_DIV_EN enables the divider; without it DIV/DIVU/REM/REMU
// never launch and read back as 0.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        synchronous abort (pipeline flush)
//   start      M-extension instruction present
//   op         md_op_t
//   a, b       forwarded operands, latched at launch
//   stall      high from the launch cycle until the result cycle
//   result     final result, valid only in the DONE cycle (0 otherwise)
module muldiv_iter
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            stall,
    output logic [XLEN-1:0] result
);

`ifdef MULDIV_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    md_state_t   state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [63:0] prod_r, prod_s;     // mul: {hi, multiplier}; div: {remainder, quotient}
    logic [31:0] opa_r, opa_s;       // original dividend, needed for REM by zero
    logic [31:0] opb_r, opb_s;       // |multiplicand| or |divisor|
    logic [2:0]  op_r, op_s;
    logic        neg_r, neg_s;       // negate product / quotient
    logic        rneg_r, rneg_s;     // negate remainder (dividend sign)
    logic        a_neg_s, b_neg_s, launch_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic [32:0] sum_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quo_fix_s, rem_fix_s;
`ifdef MULDIV_DIV_EN
    logic [32:0] rem_shift_s, diff_s;
`endif

    // Next-state, datapath step and stall generation
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        prod_s   = prod_r;
        opa_s    = opa_r;
        opb_s    = opb_r;
        op_s     = op_r;
        neg_s    = neg_r;
        rneg_s   = rneg_r;
        stall    = 1'b0;
        a_neg_s  = md_a_signed(op) & a[31];
        b_neg_s  = md_b_signed(op) & b[31];
        mag_a_s  = a_neg_s ? (32'd0 - a) : a;
        mag_b_s  = b_neg_s ? (32'd0 - b) : b;
        // Division ops only launch when the divider exists
        launch_s = start & ~clr & (~op[2] | DIV_EN);
        sum_s    = {1'b0, prod_r[63:32]} + (prod_r[0] ? {1'b0, opb_r} : 33'd0);
`ifdef MULDIV_DIV_EN
        rem_shift_s = {prod_r[63:32], prod_r[31]};
        diff_s      = rem_shift_s - {1'b0, opb_r};
`endif
        case (state_r)
            MD_IDLE: begin
                if (launch_s) begin
                    stall   = 1'b1;
                    state_s = MD_BUSY;
                    cnt_s   = 5'd31;
                    op_s    = op;
                    opa_s   = a;
                    opb_s   = mag_b_s;
                    prod_s  = {32'd0, mag_a_s};
                    neg_s   = a_neg_s ^ b_neg_s;
                    rneg_s  = a_neg_s;
                end else begin
                    state_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                stall = 1'b1;
                if (clr) begin
                    state_s = MD_IDLE;
                end else begin
                    if (op_r[2]) begin
`ifdef MULDIV_DIV_EN
                        // Restoring step: shift in next dividend bit, subtract if it fits
                        if (!diff_s[32]) begin
                            prod_s = {diff_s[31:0], prod_r[30:0], 1'b1};
                        end else begin
                            prod_s = {rem_shift_s[31:0], prod_r[30:0], 1'b0};
                        end
`else
                        prod_s = prod_r;
`endif
                    end else begin
                        prod_s = {sum_s, prod_r[31:1]};
                    end
                    cnt_s = cnt_r - 5'd1;
                    if (cnt_r == 5'd0) begin
                        state_s = MD_DONE;
                    end else begin
                        state_s = MD_BUSY;
                    end
                end
            end
            MD_DONE: begin
                // Pipeline advances this cycle; a still-present start is the same instruction
                state_s = MD_IDLE;
            end
            default: begin
                state_s = MD_IDLE;
            end
        endcase
    end

    // Sign fix-up and result selection, presented only in DONE
    always_comb begin
        prod_fix_s = neg_r  ? (64'd0 - prod_r) : prod_r;
        quo_fix_s  = neg_r  ? (32'd0 - prod_r[31:0]) : prod_r[31:0];
        rem_fix_s  = rneg_r ? (32'd0 - prod_r[63:32]) : prod_r[63:32];
        result     = 32'd0;
        if (state_r == MD_DONE) begin
            case (op_r)
                MD_MUL:                     result = prod_fix_s[31:0];
                MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix_s[63:32];
                MD_DIV, MD_DIVU:            result = (opb_r == 32'd0) ? 32'hFFFF_FFFF : quo_fix_s;
                MD_REM, MD_REMU:            result = (opb_r == 32'd0) ? opa_r : rem_fix_s;
                default:                    result = 32'd0;
            endcase
        end else begin
            result = 32'd0;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= MD_IDLE;
            cnt_r   <= 5'd0;
            prod_r  <= 64'd0;
            opa_r   <= 32'd0;
            opb_r   <= 32'd0;
            op_r    <= 3'd0;
            neg_r   <= 1'b0;
            rneg_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            prod_r  <= prod_s;
            opa_r   <= opa_s;
            opb_r   <= opb_s;
            op_r    <= op_s;
            neg_r   <= neg_s;
            rneg_r  <= rneg_s;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32 pipeline.
// Forwarding muxes, single-cycle ALU, branch/jump resolution and the
// iterative multiply/divide unit (muldiv_iter) that stalls F/D/E while busy.
// Build option: MULDIV_DIV_EN enables hardware division (see muldiv_iter).
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   clrE_i                       flush; aborts a running muldiv op
//   rd1E_i, rd2E_i, imm_extE_i   operands;  pcE_i instruction PC
//   alu_ctrlE_i, alu_srcE_i      ALU op and B-source select
//   jumpE_i, jalrE_i, branchE_i, funct3E_i  control-flow controls
//   md_validE_i, md_opE_i        M-extension request
//   forward_aE_i, forward_bE_i   forwarding selects; alu_resultM_i, resultW_i sources
//   alu_resultE_o                ALU or muldiv result
//   write_dataE_o                forwarded B (store data)
//   pc_targetE_o, pc_srcE_o      branch/jump target and taken flag
//   stallE_o                     muldiv busy
module execute_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clrE_i,
    input  logic [DATA_WIDTH-1:0]    rd1E_i,
    input  logic [DATA_WIDTH-1:0]    rd2E_i,
    input  logic [ADDRESS_WIDTH-1:0] pcE_i,
    input  logic [DATA_WIDTH-1:0]    imm_extE_i,
    input  logic [3:0]               alu_ctrlE_i,
    input  logic                     alu_srcE_i,
    input  logic                     jumpE_i,
    input  logic                     jalrE_i,
    input  logic                     branchE_i,
    input  logic [2:0]               funct3E_i,
    input  logic                     md_validE_i,
    input  logic [2:0]               md_opE_i,
    input  logic [1:0]               forward_aE_i,
    input  logic [1:0]               forward_bE_i,
    input  logic [DATA_WIDTH-1:0]    alu_resultM_i,
    input  logic [DATA_WIDTH-1:0]    resultW_i,
    output logic [DATA_WIDTH-1:0]    alu_resultE_o,
    output logic [DATA_WIDTH-1:0]    write_dataE_o,
    output logic [ADDRESS_WIDTH-1:0] pc_targetE_o,
    output logic                     pc_srcE_o,
    output logic                     stallE_o
);

    logic [DATA_WIDTH-1:0]    fwd_a_s, fwd_b_s, alu_b_s, alu_s, md_result_s;
    logic [ADDRESS_WIDTH-1:0] base_s, target_s;
    logic                     cond_s, md_stall_s;

    // Operand forwarding muxes
    always_comb begin
        case (forward_aE_i)
            FWD_W:   fwd_a_s = resultW_i;
            FWD_M:   fwd_a_s = alu_resultM_i;
            default: fwd_a_s = rd1E_i;
        endcase
        case (forward_bE_i)
            FWD_W:   fwd_b_s = resultW_i;
            FWD_M:   fwd_b_s = alu_resultM_i;
            default: fwd_b_s = rd2E_i;
        endcase
        alu_b_s = alu_srcE_i ? imm_extE_i : fwd_b_s;
    end

    // Single-cycle ALU; shift amount from B[4:0]
    always_comb begin
        case (alu_ctrlE_i)
            ALU_ADD:  alu_s = fwd_a_s + alu_b_s;
            ALU_SUB:  alu_s = fwd_a_s - alu_b_s;
            ALU_AND:  alu_s = fwd_a_s & alu_b_s;
            ALU_OR:   alu_s = fwd_a_s | alu_b_s;
            ALU_XOR:  alu_s = fwd_a_s ^ alu_b_s;
            ALU_SLL:  alu_s = fwd_a_s << alu_b_s[4:0];
            ALU_SRL:  alu_s = fwd_a_s >> alu_b_s[4:0];
            ALU_SRA:  alu_s = $signed(fwd_a_s) >>> alu_b_s[4:0];
            ALU_SLT:  alu_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(fwd_a_s) < $signed(alu_b_s))};
            ALU_SLTU: alu_s = {{(DATA_WIDTH-1){1'b0}}, (fwd_a_s < alu_b_s)};
            ALU_LUI:  alu_s = alu_b_s;
            default:  alu_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Branch condition on forwarded register operands
    always_comb begin
        case (funct3E_i)
            F3_BEQ:  cond_s = (fwd_a_s == fwd_b_s);
            F3_BNE:  cond_s = (fwd_a_s != fwd_b_s);
            F3_BLT:  cond_s = ($signed(fwd_a_s) < $signed(fwd_b_s));
            F3_BGE:  cond_s = ($signed(fwd_a_s) >= $signed(fwd_b_s));
            F3_BLTU: cond_s = (fwd_a_s < fwd_b_s);
            F3_BGEU: cond_s = (fwd_a_s >= fwd_b_s);
            default: cond_s = 1'b0;
        endcase
    end

    // Target address; JALR clears bit 0 of the sum
    always_comb begin
        base_s   = jalrE_i ? fwd_a_s[ADDRESS_WIDTH-1:0] : pcE_i;
        target_s = base_s + imm_extE_i[ADDRESS_WIDTH-1:0];
        if (jalrE_i) begin
            target_s[0] = 1'b0;
        end else begin
            target_s[0] = target_s[0];
        end
    end

    muldiv_iter u_muldiv (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (clrE_i),
        .start  (md_validE_i),
        .op     (md_opE_i),
        .a      (fwd_a_s),
        .b      (fwd_b_s),
        .stall  (md_stall_s),
        .result (md_result_s)
    );

    assign stallE_o      = md_stall_s;
    // Redirect is suppressed while the stage is held
    assign pc_srcE_o     = (jumpE_i | (branchE_i & cond_s)) & ~md_stall_s;
    assign pc_targetE_o  = target_s;
    assign write_dataE_o = fwd_b_s;
    assign alu_resultE_o = md_validE_i ? md_result_s : alu_s;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expected values into
// queues; a monitor pops and compares at the falling edge.
module tb_execute_stage;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, clrE_i;
    logic [31:0] rd1E_i, rd2E_i, pcE_i, imm_extE_i, alu_resultM_i, resultW_i;
    logic [3:0]  alu_ctrlE_i;
    logic        alu_srcE_i, jumpE_i, jalrE_i, branchE_i, md_validE_i;
    logic [2:0]  funct3E_i, md_opE_i;
    logic [1:0]  forward_aE_i, forward_bE_i;
    logic [31:0] alu_resultE_o, write_dataE_o, pc_targetE_o;
    logic        pc_srcE_o, stallE_o;

    execute_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .clrE_i(clrE_i),
        .rd1E_i(rd1E_i), .rd2E_i(rd2E_i), .pcE_i(pcE_i), .imm_extE_i(imm_extE_i),
        .alu_ctrlE_i(alu_ctrlE_i), .alu_srcE_i(alu_srcE_i),
        .jumpE_i(jumpE_i), .jalrE_i(jalrE_i), .branchE_i(branchE_i),
        .funct3E_i(funct3E_i), .md_validE_i(md_validE_i), .md_opE_i(md_opE_i),
        .forward_aE_i(forward_aE_i), .forward_bE_i(forward_bE_i),
        .alu_resultM_i(alu_resultM_i), .resultW_i(resultW_i),
        .alu_resultE_o(alu_resultE_o), .write_dataE_o(write_dataE_o),
        .pc_targetE_o(pc_targetE_o), .pc_srcE_o(pc_srcE_o), .stallE_o(stallE_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          id;
        int          field;
        logic [31:0] exp;
    } exp_t;

    exp_t comb_q[$];
    exp_t md_q[$];
    int   checks = 0;
    int   failures = 0;

    localparam int F_ALU = 0, F_PCSRC = 1, F_TGT = 2, F_STALL = 3, F_WD = 4;

    function automatic string fname(input int f);
        case (f)
            F_ALU:   return "alu_result";
            F_PCSRC: return "pc_src";
            F_TGT:   return "pc_target";
            F_STALL: return "stall";
            F_WD:    return "write_data";
            default: return "stall_len";
        endcase
    endfunction

    function automatic void chk(input int id, input int field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s actual=%h expected=%h", id, fname(field), act, exp);
        end
    endfunction

    function automatic void expect_c(input int id, input int field, input logic [31:0] exp);
        exp_t e;
        e.id = id; e.field = field; e.exp = exp;
        comb_q.push_back(e);
    endfunction

    // Monitor: combinational expectations at the next falling edge; muldiv
    // results when the DUT presents them (request present and not stalled)
    always @(negedge clk_i) begin
        exp_t e;
        logic [31:0] act;
        while (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            case (e.field)
                F_ALU:   act = alu_resultE_o;
                F_PCSRC: act = {31'd0, pc_srcE_o};
                F_TGT:   act = pc_targetE_o;
                F_STALL: act = {31'd0, stallE_o};
                default: act = write_dataE_o;
            endcase
            chk(e.id, e.field, act, e.exp);
        end
        if (md_validE_i && !stallE_o && !rst_i) begin
            if (md_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_md_result actual=%h expected=none", alu_resultE_o);
            end else begin
                e = md_q.pop_front();
                chk(e.id, F_ALU, alu_resultE_o, e.exp);
            end
        end
    end

    task automatic idle_inputs();
        clrE_i = 1'b0; rd1E_i = 32'd0; rd2E_i = 32'd0; pcE_i = 32'd0; imm_extE_i = 32'd0;
        alu_ctrlE_i = 4'd0; alu_srcE_i = 1'b0; jumpE_i = 1'b0; jalrE_i = 1'b0;
        branchE_i = 1'b0; funct3E_i = 3'd0; md_validE_i = 1'b0; md_opE_i = 3'd0;
        forward_aE_i = 2'b00; forward_bE_i = 2'b00; alu_resultM_i = 32'd0; resultW_i = 32'd0;
    endtask

    task automatic drive_alu(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic src);
        @(posedge clk_i); #1;
        idle_inputs();
        alu_ctrlE_i = ctrl; rd1E_i = a; rd2E_i = b; imm_extE_i = imm; alu_srcE_i = src;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic br, input logic jmp, input logic jr);
        @(posedge clk_i); #1;
        idle_inputs();
        funct3E_i = f3; rd1E_i = a; rd2E_i = b; pcE_i = pc; imm_extE_i = imm;
        branchE_i = br; jumpE_i = jmp; jalrE_i = jr;
    endtask

    // Issue one muldiv op, expect a result and a stall run of exp_stall cycles
    task automatic run_md(input int id, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        exp_t e;
        int   cnt;
        bit   seen;
        @(posedge clk_i); #1;
        idle_inputs();
        e.id = id; e.field = F_ALU; e.exp = exp;
        md_q.push_back(e);
        md_validE_i = 1'b1; md_opE_i = op; rd1E_i = a; rd2E_i = b;
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (!stallE_o) begin
                seen = 1'b1;
                break;
            end
            cnt++;
            // Operands must already be latched
            if (i == 1) begin
                rd1E_i = 32'hDEAD_BEEF;
                rd2E_i = 32'h1234_5678;
            end
        end
        chk(id, 9, {31'd0, seen}, 32'd1);
        chk(id, 9, cnt, exp_stall);
        @(posedge clk_i); #1;
        md_validE_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        expect_c(0, F_STALL, 32'd0);
        expect_c(0, F_PCSRC, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // ALU with forwarding
        drive_alu(ALU_ADD, 32'd99, 32'd0, 32'd7, 1'b1);
        forward_aE_i = 2'b10; alu_resultM_i = 32'd5; forward_bE_i = 2'b01; resultW_i = 32'h55;
        expect_c(1, F_ALU, 32'd12);
        expect_c(1, F_WD, 32'h55);
        drive_alu(ALU_SUB, 32'd10, 32'd3, 32'd0, 1'b0);
        expect_c(2, F_ALU, 32'd7);
        drive_alu(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        expect_c(3, F_ALU, 32'd1);
        drive_alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        expect_c(4, F_ALU, 32'd0);
        drive_alu(ALU_SRA, 32'h8000_0000, 32'h24, 32'd0, 1'b0);
        expect_c(5, F_ALU, 32'hF800_0000);
        drive_alu(ALU_LUI, 32'd1, 32'd2, 32'h1234_5000, 1'b1);
        expect_c(6, F_ALU, 32'h1234_5000);

        // Branches and jumps
        drive_br(F3_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0);
        expect_c(7, F_PCSRC, 32'd1);
        expect_c(7, F_TGT, 32'h120);
        drive_br(F3_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0);
        expect_c(8, F_PCSRC, 32'd0);
        drive_br(F3_BEQ, 32'd5, 32'd6, 32'h200, 32'h8, 1'b1, 1'b0, 1'b0);
        expect_c(9, F_PCSRC, 32'd0);
        drive_br(F3_BGE, 32'd5, 32'd5, 32'h200, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
        expect_c(10, F_PCSRC, 32'd1);
        expect_c(10, F_TGT, 32'h1F8);
        drive_br(3'd0, 32'h1003, 32'd0, 32'h300, 32'd2, 1'b0, 1'b1, 1'b1);
        expect_c(11, F_PCSRC, 32'd1);
        expect_c(11, F_TGT, 32'h1004);

        // Multiply
        run_md(12, MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_md(13, MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_md(14, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        // Reset during BUSY cycle 10 drops stall immediately
        @(posedge clk_i); #1;
        idle_inputs();
        md_validE_i = 1'b1; md_opE_i = MD_MUL; rd1E_i = 32'd3; rd2E_i = 32'd5;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        md_validE_i = 1'b0;
        #1;
        chk(15, F_STALL, {31'd0, stallE_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        run_md(16, MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

        // Flush at BUSY cycle 5
        @(posedge clk_i); #1;
        idle_inputs();
        md_validE_i = 1'b1; md_opE_i = MD_MUL; rd1E_i = 32'd3; rd2E_i = 32'd5;
        repeat (5) @(posedge clk_i);
        #1;
        clrE_i = 1'b1;
        @(negedge clk_i);
        chk(17, F_STALL, {31'd0, stallE_o}, 32'd1);
        @(posedge clk_i); #1;
        clrE_i = 1'b0;
        md_validE_i = 1'b0;
        @(negedge clk_i);
        chk(18, F_STALL, {31'd0, stallE_o}, 32'd0);
        run_md(19, MD_MUL, 32'd6, 32'd7, 32'd42, 33);

        // Division
`ifdef MULDIV_DIV_EN
        run_md(20, MD_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 33);
        run_md(21, MD_REM, 32'd100, 32'd0, 32'd100, 33);
        run_md(22, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_md(23, MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_md(24, MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_md(25, MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_md(26, MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_md(27, MD_REMU, 32'd100, 32'd7, 32'd2, 33);
`else
        run_md(20, MD_DIV, 32'd100, 32'd7, 32'd0, 0);
        run_md(21, MD_REMU, 32'd100, 32'd0, 32'd0, 0);
`endif

        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        chk(30, 9, comb_q.size() + md_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
